// File: rtl/stepdown_fault_pkg.sv
// Shared types and defaults for the step-down converter fault qualifier.
// Latency: none (declarations only).
// Backpressure: none; the fault path has no flow control.
package stepdown_fault_pkg;

   // Qualifier FSM states.
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,   // power stage enabled, watching for a fault
      ST_FILTER = 2'd1,   // fault seen, deglitching
      ST_HICCUP = 2'd2,   // fault held off for a fixed off-time (also startup blank)
      ST_LOCK   = 2'd3    // too many retries, held until cleared
   } fault_state_t;

   // Width of the retry counter; saturates at its all-ones value.
   localparam int RETRY_W = 3;
   localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

   // Default timing parameters.
   localparam int DEF_DEGLITCH_CYC = 16;
   localparam int DEF_HICCUP_CYC   = 1024;
   localparam int DEF_MAX_RETRY    = 7;
   localparam int DEF_CNT_W        = 10;

   // Saturating increment of the retry counter.
   function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] r);
      return (r == RETRY_SAT) ? r : r + RETRY_W'(1);
   endfunction

endpackage

// File: rtl/stepdown_fault_sync.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk edges from capture to q.
// Backpressure: none; free-running level path.
module stepdown_fault_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Capture the asynchronous level, then re-register it to settle metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/stepdown_fault_filter.sv
// Fault qualifier: sync + deglitch of comparator, hiccup retry, startup blank, retry lockout.
// Latency: o rises DEGLITCH_CYC+1 edges after the edge first capturing i=1; o falls 1 edge after exit decision.
// Backpressure: none; o is a held level, clr is only honoured in LOCK.
module stepdown_fault_filter
   import stepdown_fault_pkg::*;
#(
   parameter int DEGLITCH_CYC = DEF_DEGLITCH_CYC,
   parameter int HICCUP_CYC   = DEF_HICCUP_CYC,
   parameter int MAX_RETRY    = DEF_MAX_RETRY,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic               CELCLK,
   input  logic               CELRSTN,
   input  logic               CELV,
   input  logic               CELG,
   input  logic               SUB,
   input  logic               i,
   input  logic               clr,
   output logic               o,
   output logic               lockout,
   output logic [RETRY_W-1:0] retry_cnt
);

   // Terminal counts of the shared counter.
   localparam logic [CNT_W-1:0]   DG_TC   = CNT_W'(DEGLITCH_CYC - 1);
   localparam logic [CNT_W-1:0]   HIC_TC  = CNT_W'(HICCUP_CYC - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [RETRY_W-1:0] MAX_R   = RETRY_W'(MAX_RETRY);
   // MAX_RETRY of zero disables lockout entirely.
   localparam bit                 LOCK_EN = (MAX_RETRY != 0);

   // Supply, ground and substrate pins are physical connections only.
   logic unused_pwr;
   assign unused_pwr = CELV ^ CELG ^ SUB;

   logic               i_s;
   fault_state_t       state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [RETRY_W-1:0] retry_n;
   logic [RETRY_W-1:0] retry_up;
   logic               o_n;
   logic               lockout_n;

   stepdown_fault_sync u_sync (
      .clk   (CELCLK),
      .rst_n (CELRSTN),
      .d     (i),
      .q     (i_s)
   );

   // State, shared counter and registered outputs; reset lands in HICCUP as the startup blank.
   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         state     <= ST_HICCUP;
         cnt       <= '0;
         retry_cnt <= '0;
         o         <= 1'b1;
         lockout   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         retry_cnt <= retry_n;
         o         <= o_n;
         lockout   <= lockout_n;
      end
   end

   // Next state, counter and retry history; outputs decode the next state so they stay registered.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      retry_n  = retry_cnt;
      retry_up = retry_inc(retry_cnt);

      case (state)
         ST_RUN: begin
            if (i_s) begin
               // First high sample already counts toward the deglitch window.
               state_n = ST_FILTER;
               cnt_n   = CNT_ONE;
            end else if (cnt == HIC_TC) begin
               // Long enough fault-free streak: forget earlier detections, counter parks.
               retry_n = '0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

         ST_FILTER: begin
            if (!i_s) begin
               // Any low sample restarts qualification from scratch.
               state_n = ST_RUN;
               cnt_n   = '0;
            end else if (cnt < DG_TC) begin
               cnt_n = cnt + CNT_ONE;
            end else begin
               // Fault qualified.
               retry_n = retry_up;
               cnt_n   = '0;
               if (LOCK_EN && (retry_up >= MAX_R)) begin
                  state_n = ST_LOCK;
               end else begin
                  state_n = ST_HICCUP;
               end
            end
         end

         ST_HICCUP: begin
            // Off-time runs to completion regardless of the comparator.
            if (cnt == HIC_TC) begin
               cnt_n = '0;
               if (!i_s) begin
                  state_n = ST_RUN;
               end
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

         ST_LOCK: begin
            // Clear only takes effect once the comparator has gone quiet.
            if (clr && !i_s) begin
               state_n = ST_RUN;
               cnt_n   = '0;
               retry_n = '0;
            end
         end

         default: begin
            state_n = ST_HICCUP;
            cnt_n   = '0;
         end
      endcase

      o_n       = (state_n == ST_HICCUP) || (state_n == ST_LOCK);
      lockout_n = (state_n == ST_LOCK);
   end

endmodule

// File: tb/tb_stepdown_fault_filter.sv
// Self-checking bench: default-parameter DUT plus a fast no-lockout DUT, both against a streak/timer model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stepdown_fault_filter;

   logic       CELCLK;
   logic       CELRSTN;
   logic       CELV, CELG, SUB;
   logic       i, clr;
   logic       o0, lk0, o1, lk1;
   logic [2:0] rc0, rc1;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-instance parameters: [0] defaults, [1] fast no-lockout variant.
   int p_d [2] = '{16, 4};
   int p_h [2] = '{1024, 32};
   int p_m [2] = '{7, 0};

   // Model state: sync delay line, consecutive-high streak, clean-run streak,
   // remaining off-time, lock flag and detection count.
   logic m_s1 [2];
   logic m_s2 [2];
   logic m_lock [2];
   int   m_hi [2];
   int   m_lo [2];
   int   m_hic [2];
   int   m_retry [2];

   stepdown_fault_filter dut (
      .CELCLK(CELCLK), .CELRSTN(CELRSTN), .CELV(CELV), .CELG(CELG), .SUB(SUB),
      .i(i), .clr(clr), .o(o0), .lockout(lk0), .retry_cnt(rc0)
   );

   stepdown_fault_filter #(
      .DEGLITCH_CYC(4), .HICCUP_CYC(32), .MAX_RETRY(0), .CNT_W(5)
   ) dut_nl (
      .CELCLK(CELCLK), .CELRSTN(CELRSTN), .CELV(CELV), .CELG(CELG), .SUB(SUB),
      .i(i), .clr(clr), .o(o1), .lockout(lk1), .retry_cnt(rc1)
   );

   initial begin
      CELCLK = 1'b0;
      forever #5 CELCLK = ~CELCLK;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_s1[k]    = 1'b0;
         m_s2[k]    = 1'b0;
         m_lock[k]  = 1'b0;
         m_hi[k]    = 0;
         m_lo[k]    = 0;
         m_hic[k]   = p_h[k];
         m_retry[k] = 0;
      end
   endtask

   // One clock of the reference behaviour, using the synchronised level seen before the edge.
   task automatic model_step(input int k, input logic iv, input logic cv);
      logic is_v;
      is_v    = m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = iv;
      if (m_lock[k]) begin
         if (cv && !is_v) begin
            m_lock[k]  = 1'b0;
            m_retry[k] = 0;
            m_hi[k]    = 0;
            m_lo[k]    = 0;
         end
      end else if (m_hic[k] > 0) begin
         m_hic[k]--;
         if (m_hic[k] == 0) begin
            if (is_v) m_hic[k] = p_h[k];
            else begin
               m_hi[k] = 0;
               m_lo[k] = 0;
            end
         end
      end else if (is_v) begin
         m_lo[k] = 0;
         m_hi[k]++;
         if (m_hi[k] == p_d[k]) begin
            m_hi[k] = 0;
            if (m_retry[k] < 7) m_retry[k]++;
            if (p_m[k] != 0 && m_retry[k] >= p_m[k]) m_lock[k] = 1'b1;
            else m_hic[k] = p_h[k];
         end
      end else if (m_hi[k] > 0) begin
         m_hi[k] = 0;
         m_lo[k] = 0;
      end else begin
         m_lo[k]++;
         if (m_lo[k] >= p_h[k]) m_retry[k] = 0;
      end
   endtask

   function automatic logic [31:0] exp_o(input int k);
      return 32'(m_lock[k] || (m_hic[k] != 0));
   endfunction

   task automatic check_all();
      check_val("o",       32'(o0),  exp_o(0));
      check_val("lockout", 32'(lk0), 32'(m_lock[0]));
      check_val("retry",   32'(rc0), 32'(m_retry[0]));
      check_val("nl_o",    32'(o1),  exp_o(1));
      check_val("nl_lock", 32'(lk1), 32'(m_lock[1]));
      check_val("nl_rty",  32'(rc1), 32'(m_retry[1]));
   endtask

   // Drive inputs after the falling edge, advance one rising edge, check on the next falling edge.
   task automatic cyc(input logic iv, input logic cv);
      i   = iv;
      clr = cv;
      @(posedge CELCLK);
      model_step(0, iv, cv);
      model_step(1, iv, cv);
      @(negedge CELCLK);
      clr = 1'b0;
      check_all();
   endtask

   // Assert reset between clock edges and confirm outputs change before any edge.
   task automatic async_reset(input string tag);
      #2;
      CELRSTN = 1'b0;
      #1;
      check_val({tag, "_o"},   32'(o0),  32'd1);
      check_val({tag, "_lk"},  32'(lk0), 32'd0);
      check_val({tag, "_rc"},  32'(rc0), 32'd0);
      check_val({tag, "_nlo"}, 32'(o1),  32'd1);
      i = 1'b0;
      @(negedge CELCLK);
      @(negedge CELCLK);
      CELRSTN = 1'b1;
      model_reset();
   endtask

   // Repeated detections separated by short clean runs until the default instance locks.
   task automatic lock_seq();
      int iter;
      iter = 0;
      while (!m_lock[0] && iter < 12) begin
         repeat (20) cyc(1'b1, 1'b0);
         repeat (1030) cyc(1'b0, 1'b0);
         repeat ($urandom_range(0, 300)) cyc(($urandom_range(0, 7) == 0), 1'b0);
         iter++;
      end
   endtask

   initial begin
      int p;
      CELV    = 1'b1;
      CELG    = 1'b0;
      SUB     = 1'b0;
      i       = 1'b0;
      clr     = 1'b0;
      CELRSTN = 1'b1;
      model_reset();
      #2;
      CELRSTN = 1'b0;
      @(negedge CELCLK);
      check_val("rst_o",  32'(o0),  32'd1);
      check_val("rst_lk", 32'(lk0), 32'd0);
      check_val("rst_rc", 32'(rc0), 32'd0);
      @(negedge CELCLK);
      CELRSTN = 1'b1;
      model_reset();

      // Startup blank: o held exactly HICCUP_CYC cycles.
      repeat (1023) cyc(1'b0, 1'b0);
      check_val("blank_hold", 32'(o0), 32'd1);
      cyc(1'b0, 1'b0);
      check_val("blank_end", 32'(o0), 32'd0);
      check_val("blank_rc",  32'(rc0), 32'd0);
      check_val("blank_lk",  32'(lk0), 32'd0);

      // 15 high, 1 low, 15 high never qualifies.
      repeat (15) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      repeat (15) cyc(1'b1, 1'b0);
      repeat (20) cyc(1'b0, 1'b0);
      check_val("glitch_o",  32'(o0),  32'd0);
      check_val("glitch_rc", 32'(rc0), 32'd0);

      // Held fault: o rises on the 17th edge after first capture.
      repeat (17) cyc(1'b1, 1'b0);
      check_val("det_early", 32'(o0), 32'd0);
      cyc(1'b1, 1'b0);
      check_val("det_o",  32'(o0),  32'd1);
      check_val("det_rc", 32'(rc0), 32'd1);
      repeat (2600) cyc(1'b1, 1'b0);
      check_val("hold_o", 32'(o0),  32'd1);
      check_val("hold_rc", 32'(rc0), 32'd1);
      repeat (1100) cyc(1'b0, 1'b0);
      check_val("release_o", 32'(o0), 32'd0);

      // Retries accumulate to lockout.
      lock_seq();
      check_val("lock_lk", 32'(lk0), 32'd1);
      check_val("lock_o",  32'(o0),  32'd1);
      check_val("lock_rc", 32'(rc0), 32'd7);

      // Clear while the comparator is still high is ignored.
      repeat (3) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      check_val("clr_hi_lk", 32'(lk0), 32'd1);
      check_val("clr_hi_o",  32'(o0),  32'd1);
      check_val("clr_hi_rc", 32'(rc0), 32'd7);
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      check_val("clr_lo_lk", 32'(lk0), 32'd0);
      check_val("clr_lo_o",  32'(o0),  32'd0);
      check_val("clr_lo_rc", 32'(rc0), 32'd0);

      // One detection then a long clean run forgets it.
      repeat (20) cyc(1'b1, 1'b0);
      check_val("streak_det", 32'(rc0), 32'd1);
      repeat (2200) cyc(1'b0, 1'b0);
      check_val("streak_clr", 32'(rc0), 32'd0);

      // No-lockout instance: ten close detections saturate the count, never lock.
      repeat (10) begin
         repeat (8) cyc(1'b1, 1'b0);
         repeat (36) cyc(1'b0, 1'b0);
      end
      check_val("nolock_rc", 32'(rc1), 32'd7);
      check_val("nolock_lk", 32'(lk1), 32'd0);

      // Random bursty stimulus with sporadic clear pulses.
      p = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            case ($urandom_range(0, 3))
               0: p = 0;
               1: p = 10;
               2: p = 60;
               default: p = 97;
            endcase
         end
         cyc(($urandom_range(0, 99) < p), ($urandom_range(0, 49) == 0));
      end

      // Reset in the middle of deglitching.
      async_reset("rst_rand");
      repeat (1030) cyc(1'b0, 1'b0);
      repeat (8) cyc(1'b1, 1'b0);
      async_reset("rst_filter");
      repeat (5) cyc(1'b0, 1'b0);

      // Reset while locked.
      repeat (1030) cyc(1'b0, 1'b0);
      lock_seq();
      check_val("lock2_lk", 32'(lk0), 32'd1);
      async_reset("rst_lock");
      repeat (5) cyc(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
